// File: rtl/sync_fifo_if.sv
// Handshake bundle between a sync_fifo and its producer/consumer.
// master drives w_en/r_en/data_in; slave (the FIFO) drives data_out/full/empty.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH x DATA_WIDTH, registered read data.
// Ports: clk, rst_n (sync, active-high), bus (sync_fifo_if.slave).
module sync_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic full, empty;
  logic wr_acc, rd_acc;

  // Extra MSB on each pointer tells a full ring from an empty one.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
            (wr_ptr_q[AW] != rd_ptr_q[AW]);
  end

  always_comb begin
    wr_acc     = bus.w_en && !full;
    rd_acc     = bus.r_en && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is left uncleared by reset; pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=8, DATA_WIDTH=8).
// Hand-computed expectations, one check task, pass/total summary.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  sync_fifo_if #(.DATA_WIDTH(8)) bus ();

  sync_fifo #(
    .DEPTH      (8),
    .DATA_WIDTH (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.w_en    = 1'b1;
    bus.data_in = d;
    tick();
    bus.w_en    = 1'b0;
  endtask

  task automatic rd();
    bus.r_en = 1'b1;
    tick();
    bus.r_en = 1'b0;
  endtask

  initial begin
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    rst_n       = 1'b1;
    tick();
    tick();
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_dout",  32'(bus.data_out), 0);
    rst_n = 1'b0;

    wr(8'hA5);
    chk("raw_nempty", 32'(bus.empty), 0);
    rd();
    chk("raw_dout",  32'(bus.data_out), 32'hA5);
    chk("raw_empty", 32'(bus.empty), 1);

    for (int i = 1; i <= 8; i++) begin
      wr(8'(i));
      if (i == 7) chk("fill7_full", 32'(bus.full), 0);
    end
    chk("fill8_full", 32'(bus.full), 1);
    wr(8'hFF);
    chk("ovf_full", 32'(bus.full), 1);
    for (int i = 1; i <= 8; i++) begin
      rd();
      chk($sformatf("drain%0d", i), 32'(bus.data_out), i);
      if (i == 1) chk("drain1_full", 32'(bus.full), 0);
    end
    chk("drain_empty", 32'(bus.empty), 1);

    rd();
    chk("unf_dout",  32'(bus.data_out), 32'h08);
    chk("unf_empty", 32'(bus.empty), 1);
    wr(8'h3C);
    rd();
    chk("unf_ptr_dout",  32'(bus.data_out), 32'h3C);
    chk("unf_ptr_empty", 32'(bus.empty), 1);

    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      rd();
      chk($sformatf("wrapA%0d", i), 32'(bus.data_out), 32'h10 + i);
    end
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      rd();
      chk($sformatf("wrapB%0d", i), 32'(bus.data_out), 32'h20 + i);
    end
    chk("wrap_empty", 32'(bus.empty), 1);

    wr(8'h41);
    wr(8'h42);
    wr(8'h43);
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h44;
    tick();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("sim3_dout", 32'(bus.data_out), 32'h41);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sim3_nempty%0d", i), 32'(bus.empty), 0);
      rd();
      chk($sformatf("sim3_rd%0d", i), 32'(bus.data_out), 32'h42 + i);
    end
    chk("sim3_empty", 32'(bus.empty), 1);

    for (int i = 0; i < 8; i++) wr(8'h51 + 8'(i));
    chk("simf_full0", 32'(bus.full), 1);
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'hEE;
    tick();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("simf_dout", 32'(bus.data_out), 32'h51);
    chk("simf_full", 32'(bus.full), 0);
    for (int i = 0; i < 7; i++) begin
      rd();
      chk($sformatf("simf_rd%0d", i), 32'(bus.data_out), 32'h52 + i);
    end
    chk("simf_empty", 32'(bus.empty), 1);

    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h77;
    tick();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("sime_dout",   32'(bus.data_out), 32'h58);
    chk("sime_nempty", 32'(bus.empty), 0);
    rd();
    chk("sime_rd",    32'(bus.data_out), 32'h77);
    chk("sime_empty", 32'(bus.empty), 1);

    wr(8'h91);
    wr(8'h92);
    bus.w_en    = 1'b1;
    bus.data_in = 8'h93;
    rst_n       = 1'b1;
    tick();
    bus.w_en = 1'b0;
    rst_n    = 1'b0;
    chk("mrst_empty", 32'(bus.empty), 1);
    chk("mrst_full",  32'(bus.full), 0);
    chk("mrst_dout",  32'(bus.data_out), 0);
    rd();
    chk("mrst_unf", 32'(bus.data_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
